// File: rtl/window5x5_gen.sv
// 5x5 sliding-window generator for a raster-order pixel stream.
// Four line buffers hold the previous image lines. A 5x5 shift register
// gathers one new column per accepted pixel. A window is emitted only when
// it lies fully inside the image, so there is no padding.
module window5x5_gen #(
  parameter  int DATA_BITS = 8,
  parameter  int IMG_W     = 28,
  parameter  int IMG_H     = 28,
  localparam int ROW_W     = $clog2(IMG_H),
  localparam int COL_W     = $clog2(IMG_W)
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        pix_valid,
  input  logic signed [DATA_BITS-1:0] pix_in,
  output logic                        valid_out,
  output logic [25*DATA_BITS-1:0]     win,
  output logic [ROW_W-1:0]            win_row,
  output logic [COL_W-1:0]            win_col,
  output logic                        frame_done
);

  // Raster position of the next pixel to be accepted.
  logic [COL_W-1:0] col_q, col_d;
  logic [ROW_W-1:0] row_q, row_d;

  // Registered outputs and their next-state values.
  logic             valid_q, valid_d;
  logic             frame_done_q, frame_done_d;
  logic [ROW_W-1:0] win_row_q, win_row_d;
  logic [COL_W-1:0] win_col_q, win_col_d;

  // Data storage. lb_q[0] is the oldest line. win_q[r][c]: r=0 is the top row, c=0 is the left column.
  logic signed [DATA_BITS-1:0] lb_q  [4][IMG_W];
  logic signed [DATA_BITS-1:0] win_q [5][5];

  // A pixel presented while reset is high is discarded.
  logic accept_s;
  assign accept_s = pix_valid & ~rst;

  // Next-state logic for the position counters, window valid flag, window origin and frame-end pulse.
  always_comb begin
    col_d        = col_q;
    row_d        = row_q;
    valid_d      = 1'b0;
    frame_done_d = 1'b0;
    win_row_d    = win_row_q;
    win_col_d    = win_col_q;
    if (pix_valid) begin
      if (col_q == COL_W'(IMG_W - 1)) begin
        col_d = {COL_W{1'b0}};
        if (row_q == ROW_W'(IMG_H - 1)) begin
          row_d        = {ROW_W{1'b0}};
          frame_done_d = 1'b1;
        end else begin
          row_d = row_q + ROW_W'(1);
        end
      end else begin
        col_d = col_q + COL_W'(1);
      end
      // The col>=4 guard keeps windows from straddling two lines.
      // The row>=4 guard keeps the previous frame's lines out of the output.
      if ((row_q >= ROW_W'(4)) && (col_q >= COL_W'(4))) begin
        valid_d   = 1'b1;
        win_row_d = row_q - ROW_W'(4);
        win_col_d = col_q - COL_W'(4);
      end else begin
        valid_d = 1'b0;
      end
    end else begin
      valid_d = 1'b0;
    end
  end

  // Control state register with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      col_q        <= {COL_W{1'b0}};
      row_q        <= {ROW_W{1'b0}};
      valid_q      <= 1'b0;
      frame_done_q <= 1'b0;
      win_row_q    <= {ROW_W{1'b0}};
      win_col_q    <= {COL_W{1'b0}};
    end else begin
      col_q        <= col_d;
      row_q        <= row_d;
      valid_q      <= valid_d;
      frame_done_q <= frame_done_d;
      win_row_q    <= win_row_d;
      win_col_q    <= win_col_d;
    end
  end

  // Rotate one column of the line buffers: every line moves one step older and the new pixel becomes the newest.
  // Non-blocking assignment makes each read see the old content (read-before-write).
  always_ff @(posedge clk) begin
    if (accept_s) begin
      for (int k = 0; k < 3; k++) begin
        lb_q[k][col_q] <= lb_q[k+1][col_q];
      end
      lb_q[3][col_q] <= pix_in;
    end
  end

  // Shift the window one column left and load the new right-hand column.
  // The new column is four buffered lines plus the incoming pixel.
  always_ff @(posedge clk) begin
    if (accept_s) begin
      for (int r = 0; r < 5; r++) begin
        for (int c = 0; c < 4; c++) begin
          win_q[r][c] <= win_q[r][c+1];
        end
      end
      for (int r = 0; r < 4; r++) begin
        win_q[r][4] <= lb_q[r][col_q];
      end
      win_q[4][4] <= pix_in;
    end
  end

  // Flatten the window register onto the output bus, with p(r,c) at slot r*5+c.
  always_comb begin
    win = {(25*DATA_BITS){1'b0}};
    for (int r = 0; r < 5; r++) begin
      for (int c = 0; c < 5; c++) begin
        win[(r*5+c)*DATA_BITS +: DATA_BITS] = win_q[r][c];
      end
    end
  end

  assign valid_out  = valid_q;
  assign frame_done = frame_done_q;
  assign win_row    = win_row_q;
  assign win_col    = win_col_q;

endmodule

// File: tb/tb_window5x5_gen.sv
// Self-checking bench for window5x5_gen with an 8x6 image of 8-bit pixels.
// The reference model stores every pixel of the current frame in an image
// array. The expected window is read directly from that image, at rows
// r-4..r and columns c-4..c.
module tb_window5x5_gen;
  localparam int W  = 8;
  localparam int H  = 6;
  localparam int DB = 8;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic               pix_valid = 1'b0;
  logic signed [DB-1:0] pix_in = '0;
  logic               valid_out;
  logic [25*DB-1:0]   win;
  logic [2:0]         win_row;
  logic [2:0]         win_col;
  logic               frame_done;

  int n_pass  = 0;
  int n_total = 0;

  // Reference model state.
  logic [DB-1:0] img [H][W];
  int m_row = 0;
  int m_col = 0;

  window5x5_gen #(.DATA_BITS(DB), .IMG_W(W), .IMG_H(H)) dut (
    .clk(clk), .rst(rst), .pix_valid(pix_valid), .pix_in(pix_in),
    .valid_out(valid_out), .win(win), .win_row(win_row), .win_col(win_col),
    .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  // Present one cycle of input. Return what the model expects to see on the outputs one cycle later.
  task automatic drive(input bit v, input logic [DB-1:0] px,
                       output bit ev, output bit efd, output logic [25*DB-1:0] ew,
                       output logic [2:0] er, output logic [2:0] ec);
    ev = 1'b0; efd = 1'b0; ew = '0; er = 3'd0; ec = 3'd0;
    if (v) begin
      img[m_row][m_col] = px;
      if (m_row >= 4 && m_col >= 4) begin
        ev = 1'b1;
        er = 3'(m_row - 4);
        ec = 3'(m_col - 4);
        for (int i = 0; i < 5; i++)
          for (int j = 0; j < 5; j++)
            ew[(i*5+j)*DB +: DB] = img[m_row-4+i][m_col-4+j];
      end
      efd = (m_row == H-1) && (m_col == W-1);
      m_col++;
      if (m_col == W) begin
        m_col = 0;
        m_row++;
        if (m_row == H) m_row = 0;
      end
    end
    pix_valid = v;
    pix_in    = px;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst = 1'b1; pix_valid = 1'b0; pix_in = '0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    m_row = 0; m_col = 0;
    n_total++;
    if (valid_out !== 1'b0 || frame_done !== 1'b0 || win_row !== 3'd0 || win_col !== 3'd0)
      $display("FAIL reset_state: valid=%b fd=%b row=%0d col=%0d, required 0 0 0 0",
               valid_out, frame_done, win_row, win_col);
    else n_pass++;
  endtask

  task automatic test_full_frame;
    bit ev, efd; logic [25*DB-1:0] ew, first_w, last_w; logic [2:0] er, ec, lr, lc;
    bit lfd; int nv, nfd;
    nv = 0; nfd = 0; first_w = '0; last_w = '0; lr = 3'd0; lc = 3'd0; lfd = 1'b0;
    for (int p = 0; p < W*H; p++) begin
      drive(1'b1, 8'(p), ev, efd, ew, er, ec);
      n_total++;
      if (valid_out !== ev || frame_done !== efd || (ev && (win !== ew || win_row !== er || win_col !== ec)))
        $display("FAIL full_frame px%0d: valid=%b/%b fd=%b/%b row=%0d/%0d col=%0d/%0d win=%h req %h",
                 p, valid_out, ev, frame_done, efd, win_row, er, win_col, ec, win, ew);
      else n_pass++;
      if (valid_out === 1'b1) begin
        if (nv == 0) first_w = win;
        last_w = win; lr = win_row; lc = win_col; lfd = frame_done;
        nv++;
      end
      if (frame_done === 1'b1) nfd++;
    end
    n_total++;
    if (nv !== 8) $display("FAIL frame_window_count: got %0d, required 8", nv); else n_pass++;
    n_total++;
    if (first_w[7:0] !== 8'd0 || first_w[39:32] !== 8'd4 || first_w[167:160] !== 8'd32 || first_w[199:192] !== 8'd36)
      $display("FAIL first_window: p00=%0d p04=%0d p40=%0d p44=%0d, required 0 4 32 36",
               first_w[7:0], first_w[39:32], first_w[167:160], first_w[199:192]);
    else n_pass++;
    n_total++;
    if (last_w[7:0] !== 8'd11 || last_w[199:192] !== 8'd47 || lr !== 3'd1 || lc !== 3'd3 || lfd !== 1'b1)
      $display("FAIL last_window: p00=%0d p44=%0d row=%0d col=%0d fd=%b, required 11 47 1 3 1",
               last_w[7:0], last_w[199:192], lr, lc, lfd);
    else n_pass++;
    n_total++;
    if (nfd !== 1) $display("FAIL frame_done_count: got %0d, required 1", nfd); else n_pass++;
  endtask

  task automatic test_gaps;
    bit ev, efd; logic [25*DB-1:0] ew; logic [2:0] er, ec; int nv, ngap;
    nv = 0;
    for (int p = 0; p < W*H; p++) begin
      ngap = 0;
      while ($urandom_range(1, 0) == 1 && ngap < 4) begin
        ngap++;
        drive(1'b0, 8'($urandom_range(255, 0)), ev, efd, ew, er, ec);
        n_total++;
        if (valid_out !== 1'b0 || frame_done !== 1'b0)
          $display("FAIL gap_idle px%0d: valid=%b fd=%b, required 0 0", p, valid_out, frame_done);
        else n_pass++;
      end
      drive(1'b1, 8'(p), ev, efd, ew, er, ec);
      n_total++;
      if (valid_out !== ev || frame_done !== efd || (ev && (win !== ew || win_row !== er || win_col !== ec)))
        $display("FAIL gaps px%0d: valid=%b/%b fd=%b/%b row=%0d/%0d col=%0d/%0d win=%h req %h",
                 p, valid_out, ev, frame_done, efd, win_row, er, win_col, ec, win, ew);
      else n_pass++;
      if (valid_out === 1'b1) nv++;
    end
    n_total++;
    if (nv !== 8) $display("FAIL gaps_window_count: got %0d, required 8", nv); else n_pass++;
  endtask

  task automatic test_back_to_back;
    bit ev, efd; logic [25*DB-1:0] ew, w2; logic [2:0] er, ec; int nv, nfd;
    nv = 0; nfd = 0; w2 = '0;
    for (int p = 0; p < 2*W*H; p++) begin
      drive(1'b1, (p < W*H) ? 8'(p) : 8'(p - W*H + 64), ev, efd, ew, er, ec);
      n_total++;
      if (valid_out !== ev || frame_done !== efd || (ev && (win !== ew || win_row !== er || win_col !== ec)))
        $display("FAIL back_to_back px%0d: valid=%b/%b fd=%b/%b row=%0d/%0d col=%0d/%0d win=%h req %h",
                 p, valid_out, ev, frame_done, efd, win_row, er, win_col, ec, win, ew);
      else n_pass++;
      if (valid_out === 1'b1) begin
        if (nv == 8) w2 = win;
        nv++;
      end
      if (frame_done === 1'b1) nfd++;
    end
    n_total++;
    if (w2[7:0] !== 8'd64 || w2[199:192] !== 8'd100)
      $display("FAIL frame2_first_window: p00=%0d p44=%0d, required 64 100", w2[7:0], w2[199:192]);
    else n_pass++;
    n_total++;
    if (nv !== 16 || nfd !== 2)
      $display("FAIL b2b_counts: windows=%0d fd=%0d, required 16 2", nv, nfd);
    else n_pass++;
  endtask

  task automatic test_reset_mid_frame;
    bit ev, efd; logic [25*DB-1:0] ew; logic [2:0] er, ec; int nv, first_idx;
    for (int p = 0; p <= 20; p++) begin
      drive(1'b1, 8'(p), ev, efd, ew, er, ec);
      n_total++;
      if (valid_out !== ev || frame_done !== efd)
        $display("FAIL pre_reset px%0d: valid=%b/%b fd=%b/%b", p, valid_out, ev, frame_done, efd);
      else n_pass++;
    end
    // This pixel is presented during reset and must be discarded.
    rst = 1'b1; pix_valid = 1'b1; pix_in = 8'd21;
    @(posedge clk);
    #1;
    rst = 1'b0; pix_valid = 1'b0;
    m_row = 0; m_col = 0;
    n_total++;
    if (valid_out !== 1'b0 || frame_done !== 1'b0 || win_row !== 3'd0 || win_col !== 3'd0)
      $display("FAIL mid_reset_state: valid=%b fd=%b row=%0d col=%0d, required 0 0 0 0",
               valid_out, frame_done, win_row, win_col);
    else n_pass++;
    nv = 0; first_idx = -1;
    for (int p = 0; p < W*H; p++) begin
      drive(1'b1, 8'(p), ev, efd, ew, er, ec);
      n_total++;
      if (valid_out !== ev || frame_done !== efd || (ev && (win !== ew || win_row !== er || win_col !== ec)))
        $display("FAIL after_reset px%0d: valid=%b/%b fd=%b/%b row=%0d/%0d col=%0d/%0d win=%h req %h",
                 p, valid_out, ev, frame_done, efd, win_row, er, win_col, ec, win, ew);
      else n_pass++;
      if (valid_out === 1'b1) begin
        if (first_idx < 0) first_idx = p;
        nv++;
      end
    end
    n_total++;
    if (first_idx !== 36 || nv !== 8)
      $display("FAIL after_reset_first: first window at px%0d count %0d, required 36 8", first_idx, nv);
    else n_pass++;
  endtask

  task automatic test_negative;
    bit ev, efd; logic [25*DB-1:0] ew, first_w; logic [2:0] er, ec; int nv;
    nv = 0; first_w = '0;
    for (int p = 0; p < W*H; p++) begin
      drive(1'b1, 8'(-p), ev, efd, ew, er, ec);
      n_total++;
      if (valid_out !== ev || frame_done !== efd || (ev && (win !== ew || win_row !== er || win_col !== ec)))
        $display("FAIL negative px%0d: valid=%b/%b fd=%b/%b row=%0d/%0d col=%0d/%0d win=%h req %h",
                 p, valid_out, ev, frame_done, efd, win_row, er, win_col, ec, win, ew);
      else n_pass++;
      if (valid_out === 1'b1) begin
        if (nv == 0) first_w = win;
        nv++;
      end
    end
    n_total++;
    if (first_w[199:192] !== 8'hDC || first_w[39:32] !== 8'hFC || first_w[7:0] !== 8'h00)
      $display("FAIL negative_first: p44=%h p04=%h p00=%h, required dc fc 00",
               first_w[199:192], first_w[39:32], first_w[7:0]);
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_full_frame();
    test_gaps();
    test_back_to_back();
    test_reset_mid_frame();
    test_negative();
    pix_valid = 1'b0;
    repeat (2) @(posedge clk);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
